reg_i8_i8_b: RTL and testbench
==============================

Name: reg_i8_i8_b

Overview:
- 8-bit clock-enabled data register with a synchronous, active-high reset to a fixed non-zero constant (3).
- Used as a pipeline and state element in generated datapaths, with mapping onto FPGA slice flip-flops.
- Output is registered only; there is no combinational path from a or en to y.

Parameters:
- None exposed. Width is fixed at 8. Reset/init value is fixed at 8'd3 (8'b0000_0011).
- Internal constants: WIDTH = 8 (data width); INIT = 8'd3 (reset and power-up value of y).

Ports:
- clock  input  1  Single system clock; all state updates on the rising edge.
- reset  input  1  Synchronous, active-high reset; sampled on the rising edge of clock.
- a      input  8  Data input, unsigned 8-bit.
- en     input  1  Load enable, active-high.
- y      output 8  Registered data output.

Behaviour:
- One clock (clock); reset is synchronous and active-high. No asynchronous reset path.
- Power-up / configuration value of y = 8'd3. This also applies under global set/reset (GSR) assertion.
- On each rising edge of clock, evaluated in priority order:
  - reset == 1 -> y <= 8'd3, regardless of en or a.
  - reset == 0 and en == 1 -> y <= a.
  - reset == 0 and en == 0 -> y holds its previous value.
- Latency: a captured at edge N appears on y immediately after edge N; a reader sampling at edge N still sees the old value.
- Reset vs enable: reset wins when both are asserted in the same cycle.
- Reset mid-operation: y returns to 3 after the first edge with reset high. Loading resumes on the first edge with reset low and en high.
- After reset deasserts, the first edge with en=1 loads a. Until then y stays 3.
- No arithmetic, no width conversion; bits map 1:1 (y[i] <= a[i]).
- Implementation: one flip-flop per bit with clock enable driven by en.
  - Bits 0 and 1 (INIT bit = 1) use synchronous-set flops driven by reset.
  - Bits 2..7 (INIT bit = 0) use synchronous-reset flops driven by reset.
  - Each flop's INIT attribute matches the corresponding INIT bit.
- Behavioural RTL with an equivalent always block is acceptable if it synthesises to the same per-bit flops.

Test Plan:
- Reset hold: reset=1 for 16 cycles with a=9, en=1 -> y==3 throughout. On the first edge after reset deasserts (a=9, en=1), y sampled at that edge ==3.
- Load: the edge above with reset=0, en=1, a=9 -> y==9 on the following sample. Drive en=0, a=0 from then on.
- Hold: en=0, a=0 for 2+ cycles after loading 9 -> y stays 9 each cycle.
- Reset priority: y=9, then reset=1, en=1, a=0xAA for one edge -> y==3 (not 0xAA). Release reset with en=0 -> y stays 3.
- Full-range data: en=1 with a=0x00, 0xFF, 0x55, 0xA5 on consecutive edges -> y follows each value with exactly one-cycle latency.
- Enable gating: y=0x5A, then en=0 with a toggling 0x00/0xFF each cycle for 4 cycles -> y==0x5A constant. Then en=1, a=0x01 -> y==0x01.

Source files
------------

// File: rtl/reg_i8_i8_b.sv
// 8-bit clock-enabled register with synchronous reset to 8'd3.
// Each bit is a separate flop: set-type where the init bit is 1, reset-type where it is 0.
module reg_i8_i8_b (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] a,
    input  logic       en,
    output logic [7:0] y
);

    localparam int         WIDTH = 8;
    localparam logic [7:0] INIT  = 8'd3;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
            // The declaration initialiser gives the power-up value of the flop.
            logic q_reg = INIT[gi];

            if (INIT[gi]) begin : g_set
                always_ff @(posedge clock) begin
                    if (reset)
                        q_reg <= 1'b1;
                    else if (en)
                        q_reg <= a[gi];
                end
            end else begin : g_rst
                always_ff @(posedge clock) begin
                    if (reset)
                        q_reg <= 1'b0;
                    else if (en)
                        q_reg <= a[gi];
                end
            end

            assign y[gi] = q_reg;
        end
    endgenerate

endmodule

// File: tb/tb_reg_i8_i8_b.sv
// Directed plus randomized checks of reg_i8_i8_b against a behavioural register model.
module tb_reg_i8_i8_b;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] a;
    logic       en;
    logic [7:0] y;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] model_y     = 8'd3;

    reg_i8_i8_b dut (
        .clock (clock),
        .reset (reset),
        .a     (a),
        .en    (en),
        .y     (y)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed y=%h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge: y must still show the old value before the edge and the
    // new value (reset > enable > hold) just after it.
    task automatic step(input logic r, input logic e, input logic [7:0] d, input string tag);
        reset = r;
        en    = e;
        a     = d;
        @(negedge clock);
        check({tag, "_pre"}, y, model_y);
        @(posedge clock);
        #1;
        if (r)
            model_y = 8'd3;
        else if (e)
            model_y = d;
        check(tag, y, model_y);
        $display("%-10s reset=%b en=%b a=%h -> y=%h (model %h)", tag, r, e, d, y, model_y);
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        a     = 8'h00;
        #1;
        check("powerup", y, 8'd3);

        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b1, 8'd9, "rst_hold");
        check("rst_const", y, 8'd3);

        step(1'b0, 1'b1, 8'd9, "load9");
        check("load_const", y, 8'd9);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 8'h00, "hold");

        step(1'b1, 1'b1, 8'hAA, "rst_prio");
        check("prio_const", y, 8'd3);
        step(1'b0, 1'b0, 8'hAA, "rst_rel");

        step(1'b0, 1'b1, 8'h00, "full00");
        step(1'b0, 1'b1, 8'hFF, "fullFF");
        step(1'b0, 1'b1, 8'h55, "full55");
        step(1'b0, 1'b1, 8'hA5, "fullA5");

        step(1'b0, 1'b1, 8'h5A, "load5A");
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, (i % 2 == 0) ? 8'h00 : 8'hFF, "gate");
        check("gate_const", y, 8'h5A);
        step(1'b0, 1'b1, 8'h01, "load01");

        for (int i = 0; i < 200; i++)
            step(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
                 8'($urandom_range(0, 255)), "random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
